ccff_chain_loader: RTL

//  Sequences the configuration-chain DFF shift registers (ccff_head -> ... -> ccff_tail) of the fabric.

---
 rtl/ccff_chain_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes host words MSB-first into ccff_head with a gated shift enable.
// Optional readback of the old chain contents via ccff_tail when CCFF_READBACK_EN is defined.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WW  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  bits_left, bits_left_n;   // bits not yet shifted, including the one on ccff_head
  logic [CNT_W-1:0]  bit_in_word, bit_in_word_n;
  logic [CNT_W-1:0]  bl_rem;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic              head_n, shift_en_n, ready_n, busy_n, done_n, take;

  always_comb begin
    state_n       = state;
    bits_left_n   = bits_left;
    bit_in_word_n = bit_in_word;
    shreg_n       = shreg;
    head_n        = ccff_head;
    shift_en_n    = 1'b0;
    take          = word_valid && word_ready;
    bl_rem        = (state == SHIFT) ? bits_left - ONE : bits_left;
    unique case (state)
      IDLE: if (start) begin
        state_n       = FETCH;
        bits_left_n   = LEN;
        bit_in_word_n = '0;
      end
      FETCH, SHIFT: begin
        if (take) begin
          // A word accepted in the last SHIFT cycle of the previous word continues with no bubble.
          state_n       = SHIFT;
          head_n        = word_data[WORD_W-1];
          shreg_n       = word_data << 1;
          bits_left_n   = bl_rem;
          bit_in_word_n = (bl_rem >= WW) ? WW : bl_rem;
          shift_en_n    = 1'b1;
        end else if (state == SHIFT) begin
          if (bits_left == ONE) begin
            state_n       = DONE;
            bits_left_n   = '0;
            bit_in_word_n = '0;
          end else if (bit_in_word == ONE) begin
            state_n       = FETCH;
            bits_left_n   = bl_rem;
            bit_in_word_n = '0;
          end else begin
            head_n        = shreg[WORD_W-1];
            shreg_n       = shreg << 1;
            bits_left_n   = bl_rem;
            bit_in_word_n = bit_in_word - ONE;
            shift_en_n    = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == FETCH) ||
              (state_n == SHIFT && bit_in_word_n == ONE && bits_left_n > ONE);
    busy_n  = (state_n == FETCH) || (state_n == SHIFT);
    done_n  = (state_n == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state         <= IDLE;
      bits_left     <= '0;
      bit_in_word   <= '0;
      shreg         <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      word_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      bits_left     <= bits_left_n;
      bit_in_word   <= bit_in_word_n;
      shreg         <= shreg_n;
      ccff_head     <= head_n;
      ccff_shift_en <= shift_en_n;
      word_ready    <= ready_n;
      busy          <= busy_n;
      done          <= done_n;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] cap, cap_cat;
  logic [CNT_W-1:0]  cap_cnt;
  logic              rb_last;

  assign cap_cat = (cap << 1) | WORD_W'(ccff_tail);
  assign rb_last = (cap_cnt + ONE == WW) || (bits_left == ONE);

  // Tail is sampled at the same edge the chain shifts, so it returns the pre-load contents.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cap      <= '0;
      cap_cnt  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (ccff_shift_en) begin
        if (rb_last) begin
          rb_valid <= 1'b1;
          rb_data  <= cap_cat << (WW - cap_cnt - ONE);
          cap      <= '0;
          cap_cnt  <= '0;
        end else begin
          cap     <= cap_cat;
          cap_cnt <= cap_cnt + ONE;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
